uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer sitting directly downstream of the UART receiver. Drains each completed byte from the receiver's valid/read handshake into a small circular FIFO. The FIFO's head is presented to the peripheral register interface for the CPU to read. Also provides a sticky overflow flag, an occupancy count and a flow-control hold signal, so the RTS line can be held off before the buffer fills.

Parameters:
DEPTH, 4, number of byte entries; power of two, minimum 2
PAYLOAD_BITS, 8, width of each entry, matching the receiver payload
HOLD_LEVEL, 3, occupancy at or above which fifo_hold asserts; range 1..DEPTH

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
uart_rx_valid  input  1  receiver has a completed byte pending
uart_rx_data  input  PAYLOAD_BITS  receiver byte
uart_rx_read  output  1  receiver byte consumed this cycle (combinational)
fifo_data  output  PAYLOAD_BITS  head entry; meaningful only while fifo_valid=1
fifo_valid  output  1  FIFO not empty
fifo_pop  input  1  CPU read of head; ignored when empty
fifo_clear  input  1  synchronous flush and overflow clear
fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
fifo_overflow  output  1  sticky: a byte was discarded because the FIFO was full
fifo_hold  output  1  registered; 1 when fifo_count >= HOLD_LEVEL

Behaviour:
- Reset (async assert, clk-synchronous release): read/write pointers=0, count=0, fifo_valid=0, fifo_overflow=0, fifo_hold=0. fifo_data is undefined while empty; storage array is not reset.
- uart_rx_read = uart_rx_valid & ~fifo_clear. The receiver always drains in one cycle and is never stalled. The receiver drops valid on the cycle after read, so each byte is seen exactly once.
- Push condition: push = uart_rx_valid & ~fifo_clear & (~full | pop_eff).
  - push writes uart_rx_data at wr_ptr and increments wr_ptr modulo DEPTH.
- Discard condition: uart_rx_valid & ~fifo_clear & full & ~pop_eff.
  - The byte is discarded, uart_rx_read is still asserted, and fifo_overflow is set on the next edge.
- Pop rule: pop_eff = fifo_pop & fifo_valid & ~fifo_clear. pop_eff advances rd_ptr modulo DEPTH.
- Push and pop in the same cycle:
  - count unchanged; both pointers advance.
  - When full, the push is accepted because the pop frees the slot.
  - When empty, the pop is ignored and the push proceeds (count 0->1).
- Count: count <= count + push - pop_eff. count never exceeds DEPTH and never goes below 0.
  - full = (count==DEPTH); fifo_valid = (count!=0).
- fifo_data = mem[rd_ptr], read combinationally. The new head is visible in the cycle after the pop edge. A byte pushed into an empty FIFO is visible in the cycle after the push edge, with fifo_valid=1 in the same cycle.
- fifo_clear takes priority over everything:
  - next edge: pointers=0, count=0, fifo_overflow=0.
  - any uart_rx_valid in that cycle is neither read nor stored. uart_rx_read=0, so the receiver keeps the byte pending and it is accepted the following cycle.
- fifo_overflow stays 1 until fifo_clear or reset; pops do not clear it.
- fifo_hold is registered from next-state count, so it tracks fifo_count with no extra lag. It is intended to be ORed into the RTS output by the top level.
- Pointer width is $clog2(DEPTH); wrap relies on power-of-two DEPTH. Count width is $clog2(DEPTH)+1 so the value DEPTH is representable.

Test Plan:
1. Reset, then a single byte 0xA5 (valid 1 cycle) -> uart_rx_read=1 that cycle; next cycle fifo_valid=1, fifo_data=0xA5, fifo_count=1; pop -> fifo_count=0, fifo_valid=0.
2. Push 0x01,0x02,0x03 -> fifo_hold=1 once count=3; push 0x04 -> count=4; push 0x05 -> discarded, uart_rx_read=1, fifo_overflow=1, count=4; pops yield 0x01..0x04 in order.
3. Full FIFO, push 0x55 and pop on the same cycle -> count stays 4, overflow stays 0, read order continues; 0x55 emerges last.
4. Empty FIFO, push 0x3C and pop on the same cycle -> count=1, fifo_data=0x3C.
5. Wrap: 10 push/pop pairs of 0x10..0x19 with DEPTH=4 -> data order preserved across pointer wrap; count returns to 0.
6. Full FIFO with overflow set, assert fifo_clear while uart_rx_valid=1 (0x77) -> uart_rx_read=0, next edge count=0, overflow=0; following cycle 0x77 accepted, count=1. Then assert resetn=0 mid-stream with no clock edge -> outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the CPU register interface.
// Drains each received byte into a small circular FIFO, exposes the head
// entry combinationally, and reports occupancy, a sticky overflow flag and
// a registered flow-control hold used to throttle RTS before the buffer fills.
module uart_rx_fifo #(
  parameter int DEPTH        = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int HOLD_LEVEL   = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0]    uart_rx_data,
  output logic                       uart_rx_read,
  output logic [PAYLOAD_BITS-1:0]    fifo_data,
  output logic                       fifo_valid,
  input  logic                       fifo_pop,
  input  logic                       fifo_clear,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_overflow,
  output logic                       fifo_hold
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_LEVEL);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    overflow;
  logic                    hold;
  logic                    full;
  logic                    pop_eff;
  logic                    push;
  logic                    discard;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  // a byte when the CPU reads the head at the same time. A clear blocks both
  // sides and leaves the receiver byte pending for the following cycle.
  assign full     = (count == DEPTH_C);
  assign pop_eff  = fifo_pop & fifo_valid & ~fifo_clear;
  assign push     = uart_rx_valid & ~fifo_clear & (~full | pop_eff);
  assign discard  = uart_rx_valid & ~fifo_clear & full & ~pop_eff;

  assign uart_rx_read  = uart_rx_valid & ~fifo_clear;
  assign fifo_valid    = (count != '0);
  assign fifo_data     = mem[rd_ptr];
  assign fifo_count    = count;
  assign fifo_overflow = overflow;
  assign fifo_hold     = hold;

  // Next occupancy; shared by the count register and the hold flag so the
  // hold output lines up with fifo_count without an extra cycle of lag.
  always_comb begin
    count_next = count;
    if (fifo_clear) begin
      count_next = '0;
    end else begin
      case ({push, pop_eff})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  // Control state: pointers, occupancy, sticky overflow and hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      hold     <= 1'b0;
    end else begin
      count <= count_next;
      hold  <= (count_next >= HOLD_C);
      if (fifo_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push)    wr_ptr   <= wr_ptr + PTR_W'(1);
        if (pop_eff) rd_ptr   <= rd_ptr + PTR_W'(1);
        if (discard) overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care while empty, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH        = 4;
  localparam int PAYLOAD_BITS = 8;
  localparam int HOLD_LEVEL   = 3;

  logic                        clk = 1'b0;
  logic                        resetn;
  logic                        uart_rx_valid;
  logic [PAYLOAD_BITS-1:0]     uart_rx_data;
  logic                        uart_rx_read;
  logic [PAYLOAD_BITS-1:0]     fifo_data;
  logic                        fifo_valid;
  logic                        fifo_pop;
  logic                        fifo_clear;
  logic [$clog2(DEPTH):0]      fifo_count;
  logic                        fifo_overflow;
  logic                        fifo_hold;

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .HOLD_LEVEL(HOLD_LEVEL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_read(uart_rx_read),
    .fifo_data(fifo_data),
    .fifo_valid(fifo_valid),
    .fifo_pop(fifo_pop),
    .fifo_clear(fifo_clear),
    .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow),
    .fifo_hold(fifo_hold)
  );

  always #5 clk = ~clk;

  // Reference model: contents in arrival order plus the sticky flag.
  logic [PAYLOAD_BITS-1:0] model_q [$];
  bit                      model_ovf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model state.
  task automatic check_state(input string where);
    chk({where, ":count"},    32'(fifo_count),    32'(model_q.size()));
    chk({where, ":valid"},    32'(fifo_valid),    32'(model_q.size() != 0));
    if (model_q.size() != 0)
      chk({where, ":data"},   32'(fifo_data),     32'(model_q[0]));
    chk({where, ":overflow"}, 32'(fifo_overflow), 32'(model_ovf));
    chk({where, ":hold"},     32'(fifo_hold),     32'(model_q.size() >= HOLD_LEVEL));
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cyc(input bit v, input logic [PAYLOAD_BITS-1:0] d,
                     input bit p, input bit c);
    uart_rx_valid = v;
    uart_rx_data  = d;
    fifo_pop      = p;
    fifo_clear    = c;
    @(negedge clk);
    chk("rx_read", 32'(uart_rx_read), 32'(v & ~c));
    check_state("cyc");
    if (c) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (p && model_q.size() != 0) void'(model_q.pop_front());
      if (v) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else                        model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn        = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = '0;
    fifo_pop      = 1'b0;
    fifo_clear    = 1'b0;
    model_ovf     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    resetn = 1'b1;

    // 1: single byte in and out
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // 2: fill past HOLD_LEVEL, overflow on fifth byte, drain in order
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // 3: full FIFO, simultaneous push and pop is accepted
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // 4: empty FIFO, pop is ignored and push proceeds
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // 5: pointer wrap with alternating push/pop
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    idle();

    // 6: clear beats a pending byte, which then lands next cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    idle();

    // Async reset with no clock edge, from a full FIFO with overflow set
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    idle();
    resetn = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check_state("async_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 55), 8'($urandom),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
